// File: rtl/urv_dbg_mbx_host.sv
// Host side of the uRV debug mailbox: packs host bytes into mailbox writes and
// streams mailbox values the host has not yet seen back out as bytes.
`timescale 1ns/1ps
module urv_dbg_mbx_host #(
    parameter int unsigned g_timeout = 50000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [31:0] mbx_data_i,
    output logic [31:0] mbx_data_o,
    output logic        mbx_write_o
);
    localparam int unsigned TMO_W = (g_timeout > 1) ? $clog2(g_timeout) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((g_timeout == 0) ? 0 : g_timeout - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_COLLECT, RX_WRITE} rx_state_e;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

    rx_state_e         rx_state_q, rx_state_d;
    logic [1:0]        rx_cnt_q, rx_cnt_d;
    logic [23:0]       rx_word_q, rx_word_d;
    logic [31:0]       mbx_data_q, mbx_data_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    tx_state_e         tx_state_q, tx_state_d;
    logic [31:0]       tx_shift_q, tx_shift_d;
    logic [1:0]        tx_idx_q, tx_idx_d;
    logic [31:0]       shadow_q, shadow_d;
    logic [7:0]        tx_bytes [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_tx_bytes
        assign tx_bytes[gi] = tx_shift_q[8*gi +: 8];
    end

    assign mbx_data_o = mbx_data_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_word_q  <= '0;
            mbx_data_q <= '0;
            tmo_q      <= '0;
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_idx_q   <= '0;
            shadow_q   <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_word_q  <= rx_word_d;
            mbx_data_q <= mbx_data_d;
            tmo_q      <= tmo_d;
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_idx_q   <= tx_idx_d;
            shadow_q   <= shadow_d;
        end
    end

    // RX: the fourth byte goes straight into the mailbox word, so the count
    // wraps back to zero on entry to WRITE.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_word_d   = rx_word_q;
        mbx_data_d  = mbx_data_q;
        tmo_d       = tmo_q;
        rx_ready_o  = 1'b0;
        mbx_write_o = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: rx_state_d = RX_COLLECT;
            RX_COLLECT: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) begin
                    tmo_d    = '0;
                    rx_cnt_d = rx_cnt_q + 2'd1;
                    if (rx_cnt_q == 2'd3) begin
                        mbx_data_d = {rx_data_i, rx_word_q};
                        rx_state_d = RX_WRITE;
                    end else begin
                        rx_word_d[8*rx_cnt_q +: 8] = rx_data_i;
                    end
                end else if (rx_cnt_q != 2'd0) begin
                    if (g_timeout != 0 && tmo_q == TMO_LAST) begin
                        rx_cnt_d = '0;
                        tmo_d    = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            RX_WRITE: begin
                mbx_write_o = 1'b1;
                rx_state_d  = RX_COLLECT;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // TX: the shadow tracks what the host already knows; a host write wins the
    // shadow even when a CPU value is captured in the same cycle.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_idx_d   = tx_idx_q;
        shadow_d   = shadow_q;
        tx_valid_o = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (mbx_data_i != shadow_q) begin
                    tx_shift_d = mbx_data_i;
                    shadow_d   = mbx_data_i;
                    tx_idx_d   = '0;
                    tx_state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                tx_valid_o = 1'b1;
                if (tx_ready_i) begin
                    tx_idx_d = tx_idx_q + 2'd1;
                    if (tx_idx_q == 2'd3) begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (rx_state_q == RX_WRITE) begin
            shadow_d = mbx_data_q;
        end
        tx_data_o = tx_valid_o ? tx_bytes[tx_idx_q] : 8'h00;
    end
endmodule

// File: tb/tb_urv_dbg_mbx_host.sv
// Bench for urv_dbg_mbx_host: a byte/word-level model of the host link and a
// core mailbox register, checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_urv_dbg_mbx_host;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [31:0] mbx_reg;
    logic [31:0] mbx_data;
    logic        mbx_write;
    logic        cpu_wr = 1'b0;
    logic [31:0] cpu_val = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  rx_part[$];
    logic [7:0]  exp_tx[$];
    int          gap = 0;
    int          cyc = 0;
    bit          write_due = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic [31:0] exp_word = 32'h0;
    logic [31:0] last_written = 32'h0;
    logic [7:0]  t2_bytes [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    always #5 clk = ~clk;

    urv_dbg_mbx_host #(.g_timeout(TMO)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .mbx_data_i (mbx_reg),
        .mbx_data_o (mbx_data),
        .mbx_write_o(mbx_write)
    );

    // Core mailbox: CPU CSR write beats a debug write in the same cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         mbx_reg <= 32'h0;
        else if (cpu_wr)    mbx_reg <= cpu_val;
        else if (mbx_write) mbx_reg <= mbx_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the byte/word model.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rx_ready", 32'(rx_ready), 32'd0);
            chk("rst_tx_valid", 32'(tx_valid), 32'd0);
            chk("rst_tx_data", 32'(tx_data), 32'd0);
            chk("rst_mbx_write", 32'(mbx_write), 32'd0);
            chk("rst_mbx_data", mbx_data, 32'd0);
            rx_part.delete();
            exp_tx.delete();
            gap = 0;
            cyc = 0;
            write_due = 1'b0;
            prev_stall = 1'b0;
            last_written = 32'h0;
        end else begin
            if (write_due) begin
                chk("mbx_write_pulse", 32'(mbx_write), 32'd1);
                chk("mbx_write_data", mbx_data, exp_word);
                chk("rx_ready_in_write", 32'(rx_ready), 32'd0);
                last_written = exp_word;
                write_due = 1'b0;
            end else begin
                chk("mbx_write_idle", 32'(mbx_write), 32'd0);
                chk("mbx_data_hold", mbx_data, last_written);
                if (cyc >= 1) chk("rx_ready_collect", 32'(rx_ready), 32'd1);
            end
            cyc++;
            if (rx_valid && rx_ready) begin
                rx_part.push_back(rx_data);
                gap = 0;
                if (rx_part.size() == 4) begin
                    exp_word = {rx_part[3], rx_part[2], rx_part[1], rx_part[0]};
                    write_due = 1'b1;
                    rx_part.delete();
                end
            end else if (rx_part.size() != 0) begin
                gap++;
                if (TMO != 0 && gap >= TMO) begin
                    rx_part.delete();
                    gap = 0;
                end
            end
            if (prev_stall) begin
                chk("tx_valid_stable", 32'(tx_valid), 32'd1);
                chk("tx_data_stable", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) chk("tx_unexpected", 32'(tx_valid), 32'd0);
                else chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        rx_valid = 1'b1;
        rx_data = b;
        while (!rx_ready && k < 20) begin
            tick();
            k++;
        end
        if (k >= 20) chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic cpu_write(input logic [31:0] v);
        cpu_wr = 1'b1;
        cpu_val = v;
        tick();
        cpu_wr = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_tx.size() != 0 && k < 100) begin
            tick();
            k++;
        end
        chk("tx_drain", 32'(exp_tx.size()), 32'd0);
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // 1: host word write, no echo
        chk("t1_ready_after_reset", 32'(rx_ready), 32'd1);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        $display("[TB] t1 host write 0x12345678");
        chk("t1_write_pulse", 32'(mbx_write), 32'd1);
        chk("t1_write_data", mbx_data, 32'h12345678);
        chk("t1_ready_low", 32'(rx_ready), 32'd0);
        tick();
        chk("t1_one_cycle", 32'(mbx_write), 32'd0);
        chk("t1_mailbox", mbx_reg, 32'h12345678);
        idle(10);

        // 2: CPU value streamed little-endian on consecutive cycles
        $display("[TB] t2 cpu write 0xDEADBEEF");
        push_word(32'hDEADBEEF);
        cpu_write(32'hDEADBEEF);
        chk("t2_not_yet_valid", 32'(tx_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_tx_valid", 32'(tx_valid), 32'd1);
            chk("t2_tx_byte", 32'(tx_data), 32'(t2_bytes[i]));
        end
        tick();
        chk("t2_valid_drop", 32'(tx_valid), 32'd0);
        idle(5);

        // 3: stall mid-word, mailbox changes coalesce to the last value
        $display("[TB] t3 stall and coalesce");
        push_word(32'h11223344);
        cpu_write(32'h11223344);
        tick(); tick();
        chk("t3_second_byte", 32'(tx_data), 32'h33);
        tx_ready = 1'b0;
        cpu_write(32'h0000000A);
        cpu_write(32'h0000000B);
        cpu_write(32'h0000000C);
        tick(); tick();
        chk("t3_hold_valid", 32'(tx_valid), 32'd1);
        chk("t3_hold_byte", 32'(tx_data), 32'h33);
        push_word(32'h0000000C);
        tx_ready = 1'b1;
        wait_drain();
        idle(10);

        // 4: timeout at exactly TMO idle cycles, survival at TMO-1
        $display("[TB] t4 timeout");
        send_byte(8'hAA); send_byte(8'hBB);
        idle(TMO);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        chk("t4_fresh_word", mbx_data, 32'h04030201);
        idle(3);
        send_byte(8'h21); send_byte(8'h43);
        idle(TMO - 1);
        send_byte(8'h65); send_byte(8'h87);
        chk("t4_no_timeout_word", mbx_data, 32'h87654321);
        idle(5);

        // 5: CPU write collides with host write pulse
        $display("[TB] t5 collision");
        send_byte(8'h11); send_byte(8'h11); send_byte(8'h11); send_byte(8'h11);
        chk("t5_write_pulse", 32'(mbx_write), 32'd1);
        push_word(32'h55AA55AA);
        cpu_write(32'h55AA55AA);
        chk("t5_mailbox_cpu_wins", mbx_reg, 32'h55AA55AA);
        wait_drain();
        idle(10);

        // 5b: IDLE capture in the same cycle as WRITE; only the CPU value goes out
        $display("[TB] t5b capture during write");
        send_byte(8'h22); send_byte(8'h22); send_byte(8'h22);
        push_word(32'h0BADF00D);
        rx_valid = 1'b1; rx_data = 8'h22;
        cpu_wr = 1'b1; cpu_val = 32'h0BADF00D;
        tick();
        rx_valid = 1'b0; cpu_wr = 1'b0;
        wait_drain();
        idle(10);
        chk("t5b_mailbox", mbx_reg, 32'h22222222);

        // 6: asynchronous reset mid-RX and mid-TX
        $display("[TB] t6 reset mid-rx");
        send_byte(8'hA5); send_byte(8'h5A);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rx_ready_async", 32'(rx_ready), 32'd0);
        chk("t6_mbx_data_async", mbx_data, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("t6_ready_after_release", 32'(rx_ready), 32'd1);
        $display("[TB] t6 reset mid-tx");
        tx_ready = 1'b0;
        push_word(32'hCAFEF00D);
        cpu_write(32'hCAFEF00D);
        tick();
        chk("t6_tx_first_byte", 32'(tx_data), 32'h0D);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_tx_valid_async", 32'(tx_valid), 32'd0);
        chk("t6_tx_data_async", 32'(tx_data), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tx_ready = 1'b1;
        tick();
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
        chk("t6_fresh_word", mbx_data, 32'hA4A3A2A1);
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
